// File: rtl/xrv1_branch_pkg.sv
// Shared types for the mtcore branch resolution slice: result record, BHT counter, helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package xrv1_branch_pkg;

  // Upper bounds for the fields of the result record. The record is sized once
  // here, and each instance uses the low bits that match its own parameters.
  localparam int BR_PC_MAX   = 64;
  localparam int BR_ITAG_MAX = 32;
  localparam int BR_TID_MAX  = 8;

  // 2-bit saturating direction counter: 00 strong-NT .. 11 strong-T
  typedef logic [1:0] bht_ctr_t;
  localparam bht_ctr_t BHT_WNT = 2'b01;

  typedef struct packed {
    logic [BR_TID_MAX-1:0]  tid;
    logic [BR_ITAG_MAX-1:0] itag;
    logic [BR_PC_MAX-1:0]   link;     // fall-through PC, returned as link data
    logic [BR_PC_MAX-1:0]   rpc;      // corrected fetch PC
    logic                   mispred;
    logic                   squash;   // wrong-path instruction of a redirecting thread
  } br_res_t;

  // Thread-id width, never narrower than one bit
  function automatic int tid_width(input int nthreads);
    return (nthreads > 1) ? $clog2(nthreads) : 1;
  endfunction

endpackage

// File: rtl/xrv1_branch_if.sv
// Request/result/redirect bundle between execute issue, the branch unit and fetch.
// Latency: n/a (wires only).
// Backpressure: b_rdy_o gates requests; exec_b_pc_rdy_i gates the redirect.
interface xrv1_branch_if #(
  parameter int PC_W   = 32,
  parameter int ITAG_W = 8,
  parameter int TID_W  = 2
) ();
  logic              b_req_i;
  logic              b_rdy_o;
  logic [TID_W-1:0]  b_tid_i;
  logic              b_is_branch_i;
  logic              b_is_jump_i;
  logic [PC_W-1:0]   b_pc_i;
  logic [PC_W-1:0]   next_pc_i;
  logic [PC_W-1:0]   target_pc_i;
  logic              alu_cmp_res_i;
  logic              pred_taken_i;
  logic [ITAG_W-1:0] b_itag_i;
  logic              b_done_o;
  logic [ITAG_W-1:0] b_itag_o;
  logic [PC_W-1:0]   b_wb_data_o;
  logic              exec_b_pc_vld_o;
  logic              exec_b_pc_rdy_i;
  logic [PC_W-1:0]   exec_b_pc_o;
  logic [TID_W-1:0]  exec_b_tid_o;

  // Branch unit side
  modport slave (
    input  b_req_i, b_tid_i, b_is_branch_i, b_is_jump_i, b_pc_i, next_pc_i,
           target_pc_i, alu_cmp_res_i, pred_taken_i, b_itag_i, exec_b_pc_rdy_i,
    output b_rdy_o, b_done_o, b_itag_o, b_wb_data_o, exec_b_pc_vld_o,
           exec_b_pc_o, exec_b_tid_o
  );

  // Issue / fetch side
  modport master (
    output b_req_i, b_tid_i, b_is_branch_i, b_is_jump_i, b_pc_i, next_pc_i,
           target_pc_i, alu_cmp_res_i, pred_taken_i, b_itag_i, exec_b_pc_rdy_i,
    input  b_rdy_o, b_done_o, b_itag_o, b_wb_data_o, exec_b_pc_vld_o,
           exec_b_pc_o, exec_b_tid_o
  );
endinterface

// File: rtl/xrv1_branch_bht.sv
// Per-thread table of 2-bit saturating branch direction counters.
// Latency: lookup combinational (returns pre-update value); update written at the clock edge.
// Backpressure: none, one update and one lookup every cycle.
module xrv1_branch_bht
  import xrv1_branch_pkg::*;
#(
  parameter int NTHREADS_P = 4,
  parameter int TID_W      = 2,
  parameter int IDX_W      = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             upd_vld,
  input  logic [TID_W-1:0] upd_tid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic [TID_W-1:0] lkp_tid,
  input  logic [IDX_W-1:0] lkp_idx,
  output logic             lkp_taken
);

  bht_ctr_t tbl [NTHREADS_P][2**IDX_W];
  bht_ctr_t cur;
  bht_ctr_t nxt;
  logic     upd_ok;
  logic     lkp_ok;

  assign upd_ok = upd_vld && (32'(upd_tid) < NTHREADS_P);
  assign lkp_ok = 32'(lkp_tid) < NTHREADS_P;

  // Saturating step of the entry being trained
  always_comb begin
    cur = upd_ok ? tbl[upd_tid][upd_idx] : BHT_WNT;
    nxt = cur;
    if (upd_taken && cur != 2'b11) nxt = cur + 2'd1;
    else if (!upd_taken && cur != 2'b00) nxt = cur - 2'd1;
  end

  // Table storage: everything restarts weakly-not-taken
  always_ff @(posedge clk_i) begin
    if (rst_i) tbl <= '{default: BHT_WNT};
    else if (upd_ok) tbl[upd_tid][upd_idx] <= nxt;
  end

  assign lkp_taken = lkp_ok ? tbl[lkp_tid][lkp_idx][1] : 1'b0;

endmodule

// File: rtl/xrv1_branch_resolve.sv
// Branch/jump resolution: compares outcome with prediction, redirects fetch, returns link data, counts.
// Latency: 1 cycle from accept to b_done_o; redirect visible the same cycle and held until taken.
// Backpressure: requests stall only while an unaccepted redirect is pending. BHT under XRV1_BRANCH_BHT_EN.
module xrv1_branch_resolve
  import xrv1_branch_pkg::*;
#(
  parameter int pc_width_p   = 32,
  parameter int ITAG_WIDTH_P = 0,
  parameter int NTHREADS_P   = 4,
  parameter int CNT_WIDTH_P  = 32,
  parameter int BHT_IDX_P    = 6,
  localparam int TID_W       = tid_width(NTHREADS_P)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  xrv1_branch_if.slave           br,
  input  logic [pc_width_p-1:0]  pred_pc_i,
  input  logic [TID_W-1:0]       pred_tid_i,
  output logic                   pred_taken_o,
  input  logic [TID_W-1:0]       perf_tid_i,
  output logic [CNT_WIDTH_P-1:0] perf_br_cnt_o,
  output logic [CNT_WIDTH_P-1:0] perf_mis_cnt_o
);

  // The tag width has no sensible default; the instantiating core must set it
  if (ITAG_WIDTH_P < 1 || ITAG_WIDTH_P > BR_ITAG_MAX) begin : g_bad_itag
    $error("xrv1_branch_resolve: ITAG_WIDTH_P must be set to 1..%0d", BR_ITAG_MAX);
  end

  logic                   rdy;
  logic                   acc;
  logic                   tid_ok;
  logic                   is_ctl;
  logic                   taken;
  logic                   squash;
  logic                   new_redir;
  logic                   cnt_upd;
  logic                   bht_upd;
  br_res_t                res_d;
  br_res_t                res_q;
  logic                   done_q;
  logic                   redir_vld_q;
  logic [pc_width_p-1:0]  redir_pc_q;
  logic [TID_W-1:0]       redir_tid_q;
  logic [CNT_WIDTH_P-1:0] br_cnt_q  [NTHREADS_P];
  logic [CNT_WIDTH_P-1:0] mis_cnt_q [NTHREADS_P];

  assign rdy    = ~redir_vld_q | br.exec_b_pc_rdy_i;
  assign acc    = br.b_req_i & rdy;
  assign tid_ok = 32'(br.b_tid_i) < NTHREADS_P;
  assign is_ctl = br.b_is_branch_i | br.b_is_jump_i;
  assign taken  = br.b_is_jump_i | (br.b_is_branch_i & br.alu_cmp_res_i);
  // The pending redirect flushes its thread, so anything it issued meanwhile is wrong-path,
  // even in the cycle where fetch takes that redirect.
  assign squash = redir_vld_q & (redir_tid_q == br.b_tid_i);

  assign new_redir = acc & tid_ok & is_ctl & (taken ^ br.pred_taken_i) & ~squash;
  assign cnt_upd   = acc & tid_ok & is_ctl & ~squash;
  assign bht_upd   = acc & tid_ok & br.b_is_branch_i & ~squash;

  // Build the result record of the request on the bus
  always_comb begin
    res_d         = '0;
    res_d.tid     = BR_TID_MAX'(br.b_tid_i);
    res_d.itag    = BR_ITAG_MAX'(br.b_itag_i);
    res_d.link    = BR_PC_MAX'(br.next_pc_i);
    res_d.rpc     = taken ? BR_PC_MAX'(br.target_pc_i) : BR_PC_MAX'(br.next_pc_i);
    res_d.mispred = is_ctl & (taken ^ br.pred_taken_i);
    res_d.squash  = squash;
  end

  // Result register: done pulses for one cycle per accepted request
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_q <= 1'b0;
      res_q  <= '0;
    end else begin
      done_q <= acc;
      if (acc) res_q <= res_d;
    end
  end

  // Redirect holding register; a new redirect wins over the one being handed off
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      redir_vld_q <= 1'b0;
      redir_pc_q  <= '0;
      redir_tid_q <= '0;
    end else if (new_redir) begin
      redir_vld_q <= 1'b1;
      redir_pc_q  <= res_d.rpc[pc_width_p-1:0];
      redir_tid_q <= br.b_tid_i;
    end else if (br.exec_b_pc_rdy_i) begin
      redir_vld_q <= 1'b0;
    end
  end

  // Per-thread performance counters, wrapping
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      br_cnt_q  <= '{default: '0};
      mis_cnt_q <= '{default: '0};
    end else begin
      if (cnt_upd)   br_cnt_q[br.b_tid_i]  <= br_cnt_q[br.b_tid_i] + CNT_WIDTH_P'(1);
      if (new_redir) mis_cnt_q[br.b_tid_i] <= mis_cnt_q[br.b_tid_i] + CNT_WIDTH_P'(1);
    end
  end

  assign perf_br_cnt_o  = (32'(perf_tid_i) < NTHREADS_P) ? br_cnt_q[perf_tid_i]  : '0;
  assign perf_mis_cnt_o = (32'(perf_tid_i) < NTHREADS_P) ? mis_cnt_q[perf_tid_i] : '0;

  assign br.b_rdy_o         = rdy;
  assign br.b_done_o        = done_q;
  assign br.b_itag_o        = res_q.itag[ITAG_WIDTH_P-1:0];
  assign br.b_wb_data_o     = res_q.link[pc_width_p-1:0];
  assign br.exec_b_pc_vld_o = redir_vld_q;
  assign br.exec_b_pc_o     = redir_pc_q;
  assign br.exec_b_tid_o    = redir_tid_q;

  // Only part of the stored record drives outputs; the rest is kept for debug visibility
  logic unused_res;
  assign unused_res = ^res_q;

`ifdef XRV1_BRANCH_BHT_EN
  xrv1_branch_bht #(
    .NTHREADS_P (NTHREADS_P),
    .TID_W      (TID_W),
    .IDX_W      (BHT_IDX_P)
  ) u_bht (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .upd_vld   (bht_upd),
    .upd_tid   (br.b_tid_i),
    .upd_idx   (br.b_pc_i[BHT_IDX_P+1:2]),
    .upd_taken (taken),
    .lkp_tid   (pred_tid_i),
    .lkp_idx   (pred_pc_i[BHT_IDX_P+1:2]),
    .lkp_taken (pred_taken_o)
  );

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc_i, br.b_pc_i};
`else
  assign pred_taken_o = 1'b0;

  logic unused_bht_in;
  assign unused_bht_in = ^{pred_pc_i, pred_tid_i, br.b_pc_i, bht_upd};
`endif

  // Thread ids beyond the configured count are an issue-stage bug
  a_tid_legal: assert property (@(posedge clk_i) disable iff (rst_i) br.b_req_i |-> tid_ok)
    else $error("xrv1_branch_resolve: b_tid_i out of range");

endmodule
